truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_sweep_counter.sv | 54 +++++
 rtl/truth_table_sweeper.sv | 106 ++++++++++
 tb/tb_truth_table_sweeper.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned N_IN_DEF = 5;
  localparam int unsigned NVEC     = 1 << N_IN_DEF;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of vectors swept for an n-input function.
  function automatic int unsigned nvec_of(input int unsigned n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Stimulus vector register with per-vector settle window counter.
module truth_table_sweeper_sweep_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            run_i,
  output logic [N_IN-1:0] vec_o,
  output logic            last_vec_c_o,
  output logic            win_end_c_o
);

  localparam logic [CNT_W-1:0] SETTLE_W = CNT_W'(SETTLE);

  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign vec_o        = vec_q;
  assign win_end_c_o  = (cnt_q == SETTLE_W);
  assign last_vec_c_o = &vec_q;

  // Hold each vector SETTLE+1 cycles; the terminal vector returns vec to 0.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      vec_d = '0;
      cnt_d = '0;
    end else if (run_i) begin
      if (win_end_c_o) begin
        cnt_d = '0;
        vec_d = last_vec_c_o ? '0 : vec_q + N_IN'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Vector and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors of a small combinational unit and captures its truth table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [N_IN-1:0]            vec,
  input  logic                       resp,
  output logic                       busy,
  output logic                       done,
  output logic [nvec_of(N_IN)-1:0]   tt,
  output logic [N_IN:0]              ones
);

  localparam int unsigned NV = nvec_of(N_IN);
  localparam int unsigned OW = N_IN + 1;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic            clr_c, run_c;
  logic            last_vec_c, win_end_c;

  truth_table_sweeper_sweep_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_sweep_counter (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_c),
    .run_i        (run_c),
    .vec_o        (vec),
    .last_vec_c_o (last_vec_c),
    .win_end_c_o  (win_end_c)
  );

  // Next-state, capture and accumulation logic.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    ones_d  = ones_q;
    clr_c   = 1'b0;
    run_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HOLD;
          busy_d  = 1'b1;
          tt_d    = '0;
          ones_d  = '0;
          clr_c   = 1'b1;
        end
      end
      ST_HOLD: begin
        run_c = 1'b1;
        if (win_end_c) begin
          tt_d[vec] = resp;
          ones_d    = ones_q + OW'(resp);
          if (last_vec_c) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign tt   = tt_q;
  assign ones = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: three instances with SETTLE = 1, 0, 3.
module tb_truth_table_sweeper;

  localparam int unsigned SET [3] = '{1, 0, 3};

  typedef struct {
    logic [31:0] tt;
    logic [5:0]  ones;
    int unsigned edge_no;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;

  logic        rst   [3];
  logic        start [3];
  logic        resp  [3];
  logic        busy  [3];
  logic        done  [3];
  logic [4:0]  vec   [3];
  logic [31:0] tt    [3];
  logic [5:0]  ones  [3];
  int          mode  [3];

  exp_t expq [3][$];

  int checks = 0;
  int errors = 0;
  int tmo_req = 0, tmo_seen = 0;
  int rchk_req = 0, rchk_seen = 0;
  bit end_req = 1'b0, end_ack = 1'b0;

  logic d1 = 1'b0, d2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit under test: I = ~((~A&B&C) ^ (D&~E)), vec = {A,B,C,D,E}
  function automatic logic ref_f(input logic [4:0] v);
    return ~((~v[4] & v[3] & v[2]) ^ (v[1] & ~v[0]));
  endfunction

  function automatic logic resp_of(input int m, input logic [4:0] v, input logic dl);
    case (m)
      0:       return ref_f(v);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return v[0];
      default: return dl;
    endcase
  endfunction

  // Two-cycle delayed copy of the function for the SETTLE=3 instance
  always @(posedge clk) begin
    d1 <= ref_f(vec[2]);
    d2 <= d1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_sweeper #(
      .N_IN   (5),
      .SETTLE (SET[g])
    ) u_dut (
      .clk   (clk),
      .rst   (rst[g]),
      .start (start[g]),
      .vec   (vec[g]),
      .resp  (resp[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .tt    (tt[g]),
      .ones  (ones[g])
    );
    assign resp[g] = resp_of(mode[g], vec[g], d2);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected results on done, checks vec stepping and busy length
  int unsigned brun [3] = '{0, 0, 0};
  bit          prev_done [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (tmo_req != tmo_seen) begin
      check("wait_timeout", 64'(tmo_req), 64'(tmo_seen));
      tmo_seen = tmo_req;
    end
    if (rchk_req != rchk_seen) begin
      rchk_seen = rchk_req;
      for (int g = 0; g < 3; g++) begin
        if (rst[g])
          check($sformatf("reset_outputs[%0d]", g),
                64'({vec[g], busy[g], done[g], tt[g], ones[g]}), 64'(0));
      end
    end
    for (int g = 0; g < 3; g++) begin
      if (busy[g]) begin
        check($sformatf("vec_step[%0d]", g), 64'(vec[g]), 64'(5'(brun[g] / (SET[g] + 1))));
        brun[g]++;
      end
      if (done[g]) begin
        exp_t e;
        check($sformatf("busy_len[%0d]", g), 64'(brun[g]), 64'(32 * (SET[g] + 1)));
        check($sformatf("done_single[%0d]", g), 64'(prev_done[g]), 64'(0));
        check($sformatf("done_expected[%0d]", g), 64'(expq[g].size() != 0), 64'(1));
        if (expq[g].size() != 0) begin
          e = expq[g].pop_front();
          check($sformatf("tt[%0d]", g), 64'(tt[g]), 64'(e.tt));
          check($sformatf("ones[%0d]", g), 64'(ones[g]), 64'(e.ones));
          check($sformatf("done_edge[%0d]", g), 64'(cyc), 64'(e.edge_no));
        end
        brun[g] = 0;
      end else if (!busy[g]) begin
        brun[g] = 0;
      end
      prev_done[g] = done[g];
    end
    if (end_req && !end_ack) begin
      for (int g = 0; g < 3; g++)
        check($sformatf("queue_empty[%0d]", g), 64'(expq[g].size()), 64'(0));
      end_ack = 1'b1;
    end
  end

  task automatic wait_drain(input int g);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (expq[g].size() == 0) return;
    end
    expq[g].delete();
    tmo_req++;
  endtask

  // Issue one start pulse and queue the expected table; done lands 32*(SETTLE+1) edges after acceptance
  task automatic run_sweep(input int g, input logic [31:0] ett, input logic [5:0] eones);
    exp_t        e;
    int unsigned k;
    @(negedge clk);
    start[g] = 1'b1;
    k = cyc + 1;
    e.tt      = ett;
    e.ones    = eones;
    e.edge_no = k + 32 * (SET[g] + 1);
    expq[g].push_back(e);
    @(negedge clk);
    start[g] = 1'b0;
    wait_drain(g);
  endtask

  // Stimulus
  initial begin
    exp_t        e;
    int unsigned k;
    bit          found;

    rst   = '{1'b1, 1'b1, 1'b1};
    start = '{1'b0, 1'b0, 1'b0};
    mode  = '{0, 0, 4};

    repeat (2) @(posedge clk);
    #1 rchk_req++;
    @(negedge clk);
    #2 rst = '{1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);

    // Reference function, then constant responses
    run_sweep(0, 32'hBBBB_4BBB, 6'd22);
    mode[0] = 1;
    run_sweep(0, 32'hFFFF_FFFF, 6'd32);
    mode[0] = 2;
    run_sweep(0, 32'h0000_0000, 6'd0);

    // start held high: back-to-back sweeps, next accept one cycle after done
    mode[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    k = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      e.tt      = 32'hBBBB_4BBB;
      e.ones    = 6'd22;
      e.edge_no = k + 64 + 66 * s;
      expq[0].push_back(e);
    end
    wait_drain(0);
    start[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-sweep at vec = 13, then a clean full sweep
    mode[0] = 1;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (vec[0] == 5'd13) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) tmo_req++;
    rst[0] = 1'b1;
    rchk_req++;
    @(negedge clk);
    #1 rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    mode[0] = 0;
    run_sweep(0, 32'hBBBB_4BBB, 6'd22);

    // SETTLE = 0 with resp = vec[0]
    mode[1] = 3;
    run_sweep(1, 32'hAAAA_AAAA, 6'd16);

    // SETTLE = 3 with a 2-cycle delayed response
    run_sweep(2, 32'hBBBB_4BBB, 6'd22);

    repeat (5) @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
